// File: rtl/eprom_pkg.sv
// eprom_pkg: shared op codes, FSM state encoding and erased-word default
// for the EPROM programming controller.
package eprom_pkg;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ERASE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_ERASE  = 3'd1;
  localparam state_t S_WRITE  = 3'd2;
  localparam state_t S_VERIFY = 3'd3;
  localparam state_t S_READ   = 3'd4;
  localparam state_t S_SWEEP  = 3'd5;
  localparam state_t S_RESP   = 3'd6;

  localparam logic [15:0] ERASED_VAL_DEF = 16'hFFFF;

endpackage

// File: rtl/eprom_prog_ctrl.sv
// eprom_prog_ctrl: command-driven READ/WRITE/ERASE sequencer for an EPROM.
// Optional EPROM_PROG_VERIFY_EN adds write read-back and post-erase sweep.
module eprom_prog_ctrl
  import eprom_pkg::*;
#(
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 16,
  parameter int READ_LAT     = 1,
  parameter int ERASE_CYCLES = 1,
  parameter logic [DATA_W-1:0] ERASED_VAL = DATA_W'(ERASED_VAL_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_erase,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_MAX =
    (READ_LAT > ERASE_CYCLES) ? READ_LAT : ERASE_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] ER_LAST = CNT_W'(ERASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

`ifdef EPROM_PROG_VERIFY_EN
  logic [ADDR_W-1:0] sweep_idx;
  logic [ADDR_W:0]   fail_cnt;
  logic [ADDR_W:0]   fail_next;

  // Running count of non-erased words including the current read-back
  always_comb begin
    fail_next = fail_cnt
              + (ADDR_W+1)'(mem_rdata != ERASED_VAL);
  end
`endif

  // Strobes and handshakes decode straight from state so reset drops them
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign mem_we    = (state == S_WRITE);
  assign mem_erase = (state == S_ERASE);

  // Main sequencer: command decode, latency timing, response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
`ifdef EPROM_PROG_VERIFY_EN
      sweep_idx <= '0;
      fail_cnt  <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cnt <= '0;
            unique case (cmd_op)
              OP_READ: begin
                mem_addr <= cmd_addr;
                state    <= S_READ;
              end
              OP_WRITE: begin
                mem_addr  <= cmd_addr;
                mem_wdata <= cmd_wdata;
                state     <= S_WRITE;
              end
              OP_ERASE: begin
                state <= S_ERASE;
              end
              default: begin
                rsp_data <= '0;
                rsp_err  <= 1'b1;
                state    <= S_RESP;
              end
            endcase
          end
        end
        S_WRITE: begin
`ifdef EPROM_PROG_VERIFY_EN
          cnt   <= '0;
          state <= S_VERIFY;
`else
          rsp_data <= '0;
          rsp_err  <= 1'b0;
          state    <= S_RESP;
`endif
        end
        S_ERASE: begin
          if (cnt == ER_LAST) begin
`ifdef EPROM_PROG_VERIFY_EN
            cnt       <= '0;
            sweep_idx <= '0;
            fail_cnt  <= '0;
            mem_addr  <= '0;
            state     <= S_SWEEP;
`else
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            state    <= S_RESP;
`endif
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_READ: begin
          if (cnt == RD_LAST) begin
            rsp_data <= mem_rdata;
            rsp_err  <= 1'b0;
            state    <= S_RESP;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
`ifdef EPROM_PROG_VERIFY_EN
        S_VERIFY: begin
          if (cnt == RD_LAST) begin
            if (mem_rdata != mem_wdata) begin
              rsp_data <= mem_rdata;
              rsp_err  <= 1'b1;
            end else begin
              rsp_data <= '0;
              rsp_err  <= 1'b0;
            end
            state <= S_RESP;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_SWEEP: begin
          if (cnt == RD_LAST) begin
            cnt <= '0;
            if (sweep_idx == {ADDR_W{1'b1}}) begin
              rsp_data <= DATA_W'(fail_next);
              rsp_err  <= (fail_next != '0);
              state    <= S_RESP;
            end else begin
              fail_cnt  <= fail_next;
              sweep_idx <= sweep_idx + ADDR_W'(1);
              mem_addr  <= sweep_idx + ADDR_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
`endif
        S_RESP: begin
          if (rsp_ready) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eprom_prog_ctrl.sv
// tb_eprom_prog_ctrl: scoreboard bench with a behavioural EPROM
// (address 7 stuck at 0x0039) and a word-level reference model.
module tb_eprom_prog_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int RL    = 1;
  localparam int EC    = 4;
  localparam int DEPTH = 16;
`ifdef EPROM_PROG_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] d;
    logic          e;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic          mem_erase;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] mem  [DEPTH];
  logic [DW-1:0] refm [DEPTH];
  rsp_t          exp_q[$];

  int checks = 0;
  int passed = 0;
  int we_cnt = 0;
  int er_cnt = 0;
  int viol = 0;
  logic [AW-1:0] we_addr;
  logic [DW-1:0] we_data;

  eprom_prog_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL),
    .ERASE_CYCLES(EC), .ERASED_VAL(16'hFFFF)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_erase(mem_erase),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural EPROM with one stuck word
  assign mem_rdata = (mem_addr == 4'd7) ? 16'h0039 : mem[mem_addr];

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DW'(i * 257 + 3);
    end else if (mem_erase) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 16'hFFFF;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
    return (a == 4'd7) ? 16'h0039 : refm[a];
  endfunction

  // Monitor: strobe bookkeeping and scoreboard pop on response retire
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        we_cnt++;
        we_addr = mem_addr;
        we_data = mem_wdata;
      end
      if (mem_erase) er_cnt++;
      if (mem_we && mem_erase) viol++;
      if (!busy && (mem_we || mem_erase)) viol++;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          chk("rsp_data", 32'(rsp_data), 32'(e.d));
          chk("rsp_err", 32'(rsp_err), 32'(e.e));
        end
      end
    end
  end

  task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int hold,
                         input bit ovl, input logic [1:0] nop,
                         input logic [AW-1:0] na, input logic [DW-1:0] nd);
    int n;
    int lat;
    int exp_lat;
    int cnt;
    rsp_t e;
    logic [DW-1:0] rb;
    logic [DW-1:0] sd;
    logic se;
    bit stable;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_addr = a;
    cmd_wdata = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 100);
    if (!cmd_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    we_cnt = 0;
    er_cnt = 0;
    e = '0;
    exp_lat = 1;
    case (op)
      2'b00: begin
        e.d = rd(a);
        exp_lat = RL + 1;
      end
      2'b01: begin
        refm[a] = d;
        exp_lat = 2 + (VER ? RL : 0);
        if (VER) begin
          rb = rd(a);
          if (rb != d) begin
            e.d = rb;
            e.e = 1'b1;
          end
        end
      end
      2'b10: begin
        for (int i = 0; i < DEPTH; i++) refm[i] = 16'hFFFF;
        exp_lat = EC + 1 + (VER ? DEPTH * RL : 0);
        if (VER) begin
          cnt = 0;
          for (int i = 0; i < DEPTH; i++)
            if (rd(AW'(i)) != 16'hFFFF) cnt++;
          e.d = DW'(cnt);
          e.e = (cnt != 0);
        end
      end
      default: begin
        e.e = 1'b1;
      end
    endcase
    exp_q.push_back(e);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 400);
    chk("latency", 32'(lat), 32'(exp_lat));
    if (!rsp_valid) return;
    sd = rsp_data;
    se = rsp_err;
    stable = 1'b1;
    if (ovl) begin
      cmd_valid = 1'b1;
      cmd_op = nop;
      cmd_addr = na;
      cmd_wdata = nd;
    end
    repeat (hold) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== sd ||
          rsp_err !== se || cmd_ready !== 1'b0) stable = 1'b0;
    end
    if (hold > 0) chk("rsp_stable", 32'(stable), 32'd1);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("ready_after_retire", 32'(cmd_ready), 32'd1);
    chk("we_count", 32'(we_cnt), (op == 2'b01) ? 32'd1 : 32'd0);
    chk("erase_count", 32'(er_cnt), (op == 2'b10) ? 32'(EC) : 32'd0);
    if (op == 2'b01) begin
      chk("we_addr", 32'(we_addr), 32'(a));
      chk("we_data", 32'(we_data), 32'(d));
    end
  endtask

  task automatic cmd(input logic [1:0] op, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input int hold);
    run_cmd(op, a, d, hold, 1'b0, 2'b00, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) refm[i] = DW'(i * 257 + 3);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_erase", 32'(mem_erase), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    load = 1'b0;
    @(posedge clk);
    #1;

    cmd(2'b01, 4'd1, 16'h0034, 0);
    cmd(2'b00, 4'd1, 16'h0000, 1);
    cmd(2'b10, 4'd0, 16'h0000, 0);
    cmd(2'b00, 4'd10, 16'h0000, 2);
    cmd(2'b01, 4'd7, 16'h0055, 0);
    cmd(2'b10, 4'd0, 16'h0000, 1);
    run_cmd(2'b11, 4'd2, 16'h0000, 5, 1'b1, 2'b01, 4'd3, 16'hABCD);
    cmd(2'b01, 4'd3, 16'hABCD, 0);
    cmd(2'b00, 4'd3, 16'h0000, 0);

    // Reset in the middle of a 4-cycle erase pulse
    cmd_valid = 1'b1;
    cmd_op = 2'b10;
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!cmd_ready && n < 100);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("erase_active", 32'(mem_erase), 32'd1);
    for (int i = 0; i < DEPTH; i++) refm[i] = 16'hFFFF;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_erase", 32'(mem_erase), 32'd0);
    chk("rst_mid_rsp", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    chk("rst_mid_ready", 32'(cmd_ready), 32'd1);
    chk("rst_mid_queue", 32'(exp_q.size()), 32'd0);
    cmd(2'b00, 4'd10, 16'h0000, 0);

    for (int k = 0; k < 40; k++) begin
      cmd(2'($urandom_range(0, 3)), AW'($urandom), DW'($urandom),
          int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    chk("strobe_rules", 32'(viol), 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
